// File: rtl/sync_polarity_pkg.sv
// Shared constants and parameter defaults for the sync polarity normaliser.
// Imported by the interface, the channel and the top.
package sync_polarity_pkg;

    localparam logic POL_PASS = 1'b0;
    localparam logic POL_INV  = 1'b1;

    localparam int NCH_DEF      = 2;
    localparam int CW_DEF       = 16;
    localparam int LOCK_CNT_DEF = 4;

endpackage

// File: rtl/sync_polarity_norm_if.sv
// Sync bus: raw inputs S, normalised MS, applied POL and LOCK per channel.
// SYNC_POLARITY_MEAS_OUT_EN adds measured phase lengths HLEN_O/LLEN_O.
interface sync_polarity_norm_if
    import sync_polarity_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF
);

    logic [NCH-1:0] S;
    logic [NCH-1:0] MS;
    logic [NCH-1:0] POL;
    logic [NCH-1:0] LOCK;

`ifdef SYNC_POLARITY_MEAS_OUT_EN
    logic [NCH*CW-1:0] HLEN_O;
    logic [NCH*CW-1:0] LLEN_O;

    modport master (
        output S,
        input  MS, POL, LOCK, HLEN_O, LLEN_O
    );

    modport slave (
        input  S,
        output MS, POL, LOCK, HLEN_O, LLEN_O
    );
`else
    modport master (
        output S,
        input  MS, POL, LOCK
    );

    modport slave (
        input  S,
        output MS, POL, LOCK
    );
`endif

endinterface

// File: rtl/sync_polarity_chan.sv
// One sync channel: phase measurement, polarity decision and lock.
// SYNC_POLARITY_MEAS_OUT_EN adds registered hlen_o/llen_o outputs.
module sync_polarity_chan
    import sync_polarity_pkg::*;
#(
    parameter int CW       = CW_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s,
    output logic          ms,
    output logic          pol,
`ifdef SYNC_POLARITY_MEAS_OUT_EN
    output logic [CW-1:0] hlen_o,
    output logic [CW-1:0] llen_o,
`endif
    output logic          lock
);

    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] CTOP = CMAX - 1'b1;
    localparam logic [MW-1:0] LIM  = MW'(LOCK_CNT);
    localparam logic [MW-1:0] LIM1 = MW'(LOCK_CNT - 1);

    logic          rs;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hlen;
    logic [CW-1:0] llen;
    logic          hv;
    logic          lv;
    logic [MW-1:0] mm;
    logic [MW-1:0] mc;

    logic          rise;
    logic          fall;
    logic          edge_hit;
    logic          timeout;
    logic          ld_h;
    logic          ld_l;
    logic [CW-1:0] hl_n;
    logic [CW-1:0] ll_n;
    logic          hv_n;
    logic          lv_n;
    logic          decide;
    logic          cand;
    logic          pol_n;
    logic          lock_n;
    logic [MW-1:0] mm_n;
    logic [MW-1:0] mc_n;

    // Timeout fires on the clock that takes cnt to saturation.
    always_comb begin
        rise     = !rs && s;
        fall     = rs && !s;
        edge_hit = rise || fall;
        timeout  = !edge_hit && (cnt >= CTOP);
        ld_h     = armed && fall;
        ld_l     = armed && rise;
        hl_n     = ld_h ? cnt : hlen;
        ll_n     = ld_l ? cnt : llen;
        hv_n     = hv || ld_h;
        lv_n     = lv || ld_l;
        decide   = armed && edge_hit && hv_n && lv_n;
    end

    always_comb begin
        cand = pol;
        unique case (1'b1)
            (hl_n > ll_n): cand = POL_PASS;
            (hl_n < ll_n): cand = POL_INV;
            default:       cand = pol;
        endcase
    end

    always_comb begin
        pol_n  = pol;
        lock_n = lock;
        mm_n   = mm;
        mc_n   = mc;
        if (timeout) begin
            lock_n = 1'b0;
            mm_n   = '0;
            mc_n   = '0;
        end else if (decide) begin
            if (cand != pol) begin
                mc_n   = '0;
                lock_n = 1'b0;
                if (mm >= LIM1) begin
                    pol_n = ~pol;
                    mm_n  = '0;
                end else begin
                    mm_n = mm + 1'b1;
                end
            end else begin
                mm_n = '0;
                if (mc >= LIM1) begin
                    mc_n   = LIM;
                    lock_n = 1'b1;
                end else begin
                    mc_n = mc + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs    <= 1'b0;
            armed <= 1'b0;
            cnt   <= '0;
            hlen  <= '0;
            llen  <= '0;
            hv    <= 1'b0;
            lv    <= 1'b0;
            mm    <= '0;
            mc    <= '0;
            pol   <= POL_PASS;
            lock  <= 1'b0;
            ms    <= 1'b0;
        end else begin
            rs   <= s;
            ms   <= s ^ pol;
            hlen <= hl_n;
            llen <= ll_n;
            pol  <= pol_n;
            lock <= lock_n;
            mm   <= mm_n;
            mc   <= mc_n;
            if (edge_hit) begin
                cnt <= '0;
            end else if (cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end
            if (timeout) begin
                armed <= 1'b0;
                hv    <= 1'b0;
                lv    <= 1'b0;
            end else begin
                armed <= armed || edge_hit;
                hv    <= hv_n;
                lv    <= lv_n;
            end
        end
    end

`ifdef SYNC_POLARITY_MEAS_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hlen_o <= '0;
            llen_o <= '0;
        end else begin
            hlen_o <= hlen;
            llen_o <= llen;
        end
    end
`endif

endmodule

// File: rtl/sync_polarity_norm.sv
// Per-channel sync polarity normaliser: long phase high, short pulse low.
// SYNC_POLARITY_MEAS_OUT_EN exposes measured phase lengths on the bus.
module sync_polarity_norm
    import sync_polarity_pkg::*;
#(
    parameter int NCH      = NCH_DEF,
    parameter int CW       = CW_DEF,
    parameter int LOCK_CNT = LOCK_CNT_DEF
) (
    input logic                 PCLK,
    input logic                 RESET_N,
    sync_polarity_norm_if.slave bus
);

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        sync_polarity_chan #(
            .CW       (CW),
            .LOCK_CNT (LOCK_CNT)
        ) u_chan (
            .clk    (PCLK),
            .rst_n  (RESET_N),
            .s      (bus.S[n]),
            .ms     (bus.MS[n]),
            .pol    (bus.POL[n]),
`ifdef SYNC_POLARITY_MEAS_OUT_EN
            .hlen_o (bus.HLEN_O[n*CW +: CW]),
            .llen_o (bus.LLEN_O[n*CW +: CW]),
`endif
            .lock   (bus.LOCK[n])
        );
    end

endmodule
